// File: rtl/branch_pc_unit.sv
// Program-counter and branch-resolution stage: resolves branch opcodes against ALU
// flags, owns the PC, emits the BL link write, a one-cycle flush, HALT and a taken count.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFF_W    = 22,
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [3:0]        br_op,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic [31:0]       reg_target,
  input  logic              neg_in,
  input  logic              zero_in,
  input  logic              carry_in,
  output logic [31:0]       pc,
  output logic              flush,
  output logic              link_we,
  output logic [4:0]        link_addr,
  output logic [31:0]       link_data,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_cnt
);

  // state | meaning
  // RUN   | issuing; resolve br_op when instr_valid
  // FLUSH | one cycle squashing the wrong-path instruction after a taken branch
  // HALT  | HALT executed; frozen until rst
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  localparam logic [3:0] OP_B    = 4'd1;
  localparam logic [3:0] OP_BR   = 4'd2;
  localparam logic [3:0] OP_BLTZ = 4'd3;
  localparam logic [3:0] OP_BZ   = 4'd4;
  localparam logic [3:0] OP_BNZ  = 4'd5;
  localparam logic [3:0] OP_BL   = 4'd6;
  localparam logic [3:0] OP_BCY  = 4'd7;
  localparam logic [3:0] OP_BNCY = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  state_t      state;
  logic [31:0] pc_inc;
  logic [31:0] off_ext;
  logic [31:0] rel_target;
  logic [31:0] br_target;
  logic [31:0] next_target;
  logic        cond_taken;

  assign link_addr  = LINK_REG;
  assign pc_inc     = pc + 32'd4;
  assign off_ext    = {{(32-OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign rel_target = pc_inc + (off_ext << 2);
  // masking keeps every reg_target bit in use while forcing word alignment
  assign br_target  = reg_target & ~32'd3;

  always_comb begin
    cond_taken  = 1'b0;
    next_target = rel_target;
    case (br_op)
      OP_B:    cond_taken = 1'b1;
      OP_BR: begin
        cond_taken  = 1'b1;
        next_target = br_target;
      end
      OP_BLTZ: cond_taken = neg_in;
      OP_BZ:   cond_taken = zero_in;
      OP_BNZ:  cond_taken = ~zero_in;
      OP_BL:   cond_taken = 1'b1;
      OP_BCY:  cond_taken = carry_in;
      OP_BNCY: cond_taken = ~carry_in;
      default: cond_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= 32'd0;
      halted    <= 1'b0;
      taken_cnt <= '0;
    end else if (!stall) begin
      case (state)
        S_RUN: begin
          flush   <= 1'b0;
          link_we <= 1'b0;
          if (instr_valid) begin
            if (br_op == OP_HALT) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else if (cond_taken) begin
              pc    <= next_target;
              flush <= 1'b1;
              state <= S_FLUSH;
              if (!(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
              if (br_op == OP_BL) begin
                link_we   <= 1'b1;
                link_data <= pc_inc;
              end
            end else begin
              pc <= pc_inc;
            end
          end
        end
        S_FLUSH: begin
          flush   <= 1'b0;
          link_we <= 1'b0;
          state   <= S_RUN;
        end
        S_HALT: begin
          flush   <= 1'b0;
          link_we <= 1'b0;
          halted  <= 1'b1;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: the driver pushes model-predicted outputs per
// cycle, a monitor pops and compares after each rising edge.
module tb_branch_pc_unit;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              instr_valid = 1'b0;
  logic [3:0]        br_op = 4'd0;
  logic [21:0]       br_offset = 22'd0;
  logic [31:0]       reg_target = 32'd0;
  logic              neg_in = 1'b0;
  logic              zero_in = 1'b0;
  logic              carry_in = 1'b0;
  logic [31:0]       pc;
  logic              flush;
  logic              link_we;
  logic [4:0]        link_addr;
  logic [31:0]       link_data;
  logic              halted;
  logic [CNT_W-1:0]  taken_cnt;

  always #5 clk = ~clk;

  branch_pc_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .br_op(br_op),
    .br_offset(br_offset), .reg_target(reg_target), .neg_in(neg_in), .zero_in(zero_in),
    .carry_in(carry_in), .pc(pc), .flush(flush), .link_we(link_we), .link_addr(link_addr),
    .link_data(link_data), .halted(halted), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    bit          flush;
    bit          link_we;
    logic [31:0] link_data;
    bit          halted;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model: architectural view of the stage
  logic [31:0] m_pc;
  bit          m_flush, m_link_we, m_halted;
  logic [31:0] m_link_data;
  int          m_cnt;

  task automatic model_step(input bit r, input bit st, input bit v, input logic [3:0] op,
                            input logic [21:0] off, input logic [31:0] tgt,
                            input bit n, input bit z, input bit c);
    bit take;
    int o;
    logic [31:0] dest;
    if (r) begin
      m_pc = 32'h0; m_flush = 0; m_link_we = 0; m_link_data = 32'h0; m_halted = 0; m_cnt = 0;
    end else if (st || m_halted) begin
      // frozen
    end else if (m_flush) begin
      m_flush = 0;
      m_link_we = 0;
    end else begin
      m_link_we = 0;
      if (v) begin
        case (op)
          4'd1, 4'd2, 4'd6: take = 1;
          4'd3: take = n;
          4'd4: take = z;
          4'd5: take = !z;
          4'd7: take = c;
          4'd8: take = !c;
          default: take = 0;
        endcase
        o = int'($signed(off));
        if (op == 4'd2) dest = {tgt[31:2], 2'b00};
        else dest = m_pc + 32'd4 + 32'(o * 4);
        if (op == 4'd9) m_halted = 1;
        else if (take) begin
          if (op == 4'd6) begin
            m_link_we = 1;
            m_link_data = m_pc + 32'd4;
          end
          m_pc = dest;
          m_flush = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit v, input logic [3:0] op,
                       input logic [21:0] off, input logic [31:0] tgt,
                       input bit n, input bit z, input bit c);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; instr_valid = v; br_op = op; br_offset = off;
    reg_target = tgt; neg_in = n; zero_in = z; carry_in = c;
    model_step(r, st, v, op, off, tgt, n, z, c);
    e.pc = m_pc; e.flush = m_flush; e.link_we = m_link_we; e.link_data = m_link_data;
    e.halted = m_halted; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [21:0] off, input logic [31:0] tgt,
                       input bit n, input bit z, input bit c);
    drive(0, 0, 1, op, off, tgt, n, z, c);
  endtask

  task automatic junk_cycle();
    drive(0, 0, 1, 4'd1, 22'h3FFFFF, 32'hDEAD_BEEF, 1, 1, 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("flush", 32'(flush), 32'(e.flush));
        chk("link_we", 32'(link_we), 32'(e.link_we));
        chk("link_data", link_data, e.link_data);
        chk("halted", 32'(halted), 32'(e.halted));
        chk("taken_cnt", 32'(taken_cnt), 32'(e.cnt));
        chk("link_addr", 32'(link_addr), 32'd31);
      end
    end
  end

  initial begin
    logic [3:0] op;
    drive(1, 0, 0, 4'd0, 22'd0, 32'd0, 0, 0, 0);
    drive(1, 0, 0, 4'd0, 22'd0, 32'd0, 0, 0, 0);
    repeat (3) issue(4'd0, 22'd0, 32'd0, 0, 0, 0);
    // BZ taken and not-taken from 0x100
    issue(4'd2, 22'd0, 32'h100, 0, 0, 0);
    junk_cycle();
    issue(4'd4, 22'd4, 32'd0, 0, 1, 0);
    junk_cycle();
    issue(4'd2, 22'd0, 32'h100, 0, 0, 0);
    junk_cycle();
    issue(4'd4, 22'd4, 32'd0, 0, 0, 0);
    // BL with negative offset from 0x200
    issue(4'd2, 22'd0, 32'h200, 0, 0, 0);
    junk_cycle();
    issue(4'd6, 22'h3FFFFE, 32'd0, 0, 0, 0);
    junk_cycle();
    issue(4'd0, 22'd0, 32'd0, 0, 0, 0);
    issue(4'd2, 22'd0, 32'h1237, 0, 0, 0);
    junk_cycle();
    issue(4'd7, 22'd8, 32'd0, 0, 0, 0);
    issue(4'd8, 22'd1, 32'd0, 0, 0, 0);
    // stall held across FLUSH, then released
    repeat (3) drive(0, 1, 1, 4'd1, 22'd5, 32'd0, 0, 0, 0);
    junk_cycle();
    issue(4'd3, 22'd2, 32'd0, 1, 0, 0);
    issue(4'd5, 22'd2, 32'd0, 0, 0, 0);
    issue(4'd0, 22'd0, 32'd0, 0, 0, 0);
    // BL then stall: link_we must hold
    issue(4'd6, 22'd3, 32'd0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 4'd0, 22'd0, 32'd0, 0, 0, 0);
    junk_cycle();
    // reset in the middle of FLUSH
    issue(4'd1, 22'd10, 32'd0, 0, 0, 0);
    drive(1, 1, 1, 4'd1, 22'd0, 32'd0, 0, 0, 0);
    issue(4'd0, 22'd0, 32'd0, 0, 0, 0);
    // wrap-around of pc+4 and of relative target
    issue(4'd2, 22'd0, 32'hFFFF_FFFC, 0, 0, 0);
    junk_cycle();
    issue(4'd0, 22'd0, 32'd0, 0, 0, 0);
    issue(4'd2, 22'd0, 32'hFFFF_FFF0, 0, 0, 0);
    junk_cycle();
    issue(4'd1, 22'd4, 32'd0, 0, 0, 0);
    junk_cycle();
    issue(4'd15, 22'd4, 32'd0, 0, 0, 0);
    // HALT then ignored branches
    issue(4'd9, 22'd0, 32'd0, 0, 0, 0);
    repeat (3) issue(4'd1, 22'd7, 32'd0, 0, 0, 0);
    drive(0, 1, 1, 4'd2, 22'd0, 32'h40, 0, 0, 0);
    drive(1, 0, 0, 4'd0, 22'd0, 32'd0, 0, 0, 0);
    issue(4'd0, 22'd0, 32'd0, 0, 0, 0);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd9 && $urandom_range(0, 3) != 0) op = 4'd0;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 80,
            op, 22'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drive(0, 0, 0, 4'd0, 22'd0, 32'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
